// File: rtl/gpp_alu_pkg.sv
// ============================================================================
// Module      : gpp_alu_pkg
// Description : Shared width, ALU op-code and instruction-field constants.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package gpp_alu_pkg;

    localparam int D_WIDTH = 32;

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_MUL = 3'b010;
    localparam logic [2:0] c_DIV = 3'b011;
    localparam logic [2:0] c_SLL = 3'b100;
    localparam logic [2:0] c_SRL = 3'b101;

    localparam int c_OP_MSB  = 31;
    localparam int c_OP_LSB  = 26;
    localparam int c_RS_MSB  = 25;
    localparam int c_RS_LSB  = 21;
    localparam int c_RT_MSB  = 20;
    localparam int c_RT_LSB  = 16;
    localparam int c_RD_MSB  = 15;
    localparam int c_RD_LSB  = 11;
    localparam int c_SH_MSB  = 10;
    localparam int c_SH_LSB  = 6;
    localparam int c_FN_MSB  = 5;
    localparam int c_FN_LSB  = 0;
    localparam int c_IMM_MSB = 15;
    localparam int c_IMM_LSB = 0;

    localparam int c_SHAMT_W = 5;

endpackage

`default_nettype wire

// File: rtl/gpp_alu_if.sv
// ============================================================================
// Module      : gpp_alu_if
// Description : Request/response bundle between an ALU client and gpp_alu.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface gpp_alu_if #(
    parameter int D_WIDTH = gpp_alu_pkg::D_WIDTH
);
    logic [31:0]        instr;
    logic [2:0]         op_code;
    logic [D_WIDTH-1:0] operand1;
    logic [D_WIDTH-1:0] operand2;
    logic               enable;

    logic [5:0]         op;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         sh;
    logic [5:0]         fn;
    logic [D_WIDTH-1:0] imm;
    logic [D_WIDTH-1:0] result;
    logic               valid;
    logic               div_by_zero;

    modport master (
        output instr, op_code, operand1, operand2, enable,
        input  op, rs, rt, rd, sh, fn, imm, result, valid, div_by_zero
    );

    modport slave (
        input  instr, op_code, operand1, operand2, enable,
        output op, rs, rt, rd, sh, fn, imm, result, valid, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/gpp_alu_instr_decoder.sv
// ============================================================================
// Module      : instr_decoder
// Description : Purely combinational split of a 32-bit instruction word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_decoder #(
    parameter int D_WIDTH = gpp_alu_pkg::D_WIDTH
) (
    input  wire logic [31:0]        i_instr,
    output logic      [5:0]         o_op,
    output logic      [4:0]         o_rs,
    output logic      [4:0]         o_rt,
    output logic      [4:0]         o_rd,
    output logic      [4:0]         o_sh,
    output logic      [5:0]         o_fn,
    output logic      [D_WIDTH-1:0] o_imm
);
    import gpp_alu_pkg::*;

    assign o_op  = i_instr[c_OP_MSB:c_OP_LSB];
    assign o_rs  = i_instr[c_RS_MSB:c_RS_LSB];
    assign o_rt  = i_instr[c_RT_MSB:c_RT_LSB];
    assign o_rd  = i_instr[c_RD_MSB:c_RD_LSB];
    assign o_sh  = i_instr[c_SH_MSB:c_SH_LSB];
    assign o_fn  = i_instr[c_FN_MSB:c_FN_LSB];
    assign o_imm = {{(D_WIDTH-16){1'b0}}, i_instr[c_IMM_MSB:c_IMM_LSB]};

endmodule

`default_nettype wire

// File: rtl/gpp_alu.sv
// ============================================================================
// Module      : gpp_alu
// Description : Instruction field decoder plus single-cycle registered ALU.
//               Multiply/divide present only when ALU_MULDIV_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module gpp_alu #(
    parameter int D_WIDTH = gpp_alu_pkg::D_WIDTH
) (
    input  wire logic  clk,
    input  wire logic  rst,
    gpp_alu_if.slave   bus
);
    import gpp_alu_pkg::*;

    logic [D_WIDTH-1:0]   w_result;
    logic                 w_dbz;
    logic [c_SHAMT_W-1:0] w_shamt;

    logic [D_WIDTH-1:0]   r_result;
    logic                 r_valid;
    logic                 r_dbz;

    instr_decoder #(
        .D_WIDTH (D_WIDTH)
    ) u_instr_decoder (
        .i_instr (bus.instr),
        .o_op    (bus.op),
        .o_rs    (bus.rs),
        .o_rt    (bus.rt),
        .o_rd    (bus.rd),
        .o_sh    (bus.sh),
        .o_fn    (bus.fn),
        .o_imm   (bus.imm)
    );

    // Only the low five bits of operand2 steer the shifter.
    assign w_shamt = bus.operand2[c_SHAMT_W-1:0];

    always_comb begin
        w_result = '0;
        w_dbz    = 1'b0;
        case (bus.op_code)
            c_ADD: w_result = bus.operand1 + bus.operand2;
            c_SUB: w_result = bus.operand1 - bus.operand2;
`ifdef ALU_MULDIV_EN
            c_MUL: w_result = bus.operand1 * bus.operand2;
            c_DIV: begin
                if (bus.operand2 == '0) begin
                    w_result = '1;
                    w_dbz    = 1'b1;
                end else begin
                    w_result = bus.operand1 / bus.operand2;
                end
            end
`else
            c_MUL: w_result = '0;
            c_DIV: w_result = '0;
`endif
            c_SLL: w_result = bus.operand1 << w_shamt;
            c_SRL: w_result = bus.operand1 >> w_shamt;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (bus.enable) begin
            r_result <= w_result;
            r_valid  <= 1'b1;
            r_dbz    <= w_dbz;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign bus.result      = r_result;
    assign bus.valid       = r_valid;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_gpp_alu.sv
// ============================================================================
// Module      : tb_gpp_alu
// Description : Self-checking bench for gpp_alu (decode, ALU ops, hold, reset).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_gpp_alu;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    longint unsigned exp_result;
    logic            exp_valid;
    logic            exp_dbz;

    gpp_alu_if #(.D_WIDTH(32)) bus ();

    gpp_alu #(.D_WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: values held in 64 bits, masked to 32.
    function automatic void ref_alu(input logic [2:0] opc, input longint unsigned a,
                                    input longint unsigned b,
                                    output longint unsigned r, output logic dz);
        longint unsigned mask;
        mask = 64'hFFFF_FFFF;
        dz   = 1'b0;
        r    = 0;
        case (opc)
            3'd0: r = (a + b) & mask;
            3'd1: r = (a + (64'h1_0000_0000 - b)) & mask;
`ifdef ALU_MULDIV_EN
            3'd2: r = (a * b) & mask;
            3'd3: begin
                if (b == 0) begin r = mask; dz = 1'b1; end
                else r = a / b;
            end
`endif
            3'd4: r = (a << (b % 32)) & mask;
            3'd5: r = a >> (b % 32);
            default: r = 0;
        endcase
    endfunction

    // One clock with the given request; the model advances alongside.
    task automatic drive_cycle(input logic en, input logic [2:0] opc,
                               input logic [31:0] a, input logic [31:0] b);
        longint unsigned r;
        logic dz;
        bus.enable   = en;
        bus.op_code  = opc;
        bus.operand1 = a;
        bus.operand2 = b;
        @(posedge clk);
        if (en) begin
            ref_alu(opc, longint'(a), longint'(b), r, dz);
            exp_result = r;
            exp_dbz    = dz;
            exp_valid  = 1'b1;
        end else begin
            exp_valid  = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.result !== 32'h0 || bus.valid !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset: result=%h valid=%b dbz=%b required 0/0/0",
                     bus.result, bus.valid, bus.div_by_zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_result = 0; exp_valid = 1'b0; exp_dbz = 1'b0;
    endtask

    task automatic test_decode();
        bus.instr = 32'h2001_000A;
        #1;
        total++;
        if (bus.op !== 6'd8 || bus.rs !== 5'd0 || bus.rt !== 5'd1 || bus.imm !== 32'd10) begin
            bad++;
            $display("FAIL decode_i: op=%0d rs=%0d rt=%0d imm=%0d required 8/0/1/10",
                     bus.op, bus.rs, bus.rt, bus.imm);
        end
        bus.instr = 32'h0043_2020;
        #1;
        total++;
        if (bus.rs !== 5'd2 || bus.rt !== 5'd3 || bus.rd !== 5'd4 || bus.sh !== 5'd0 || bus.fn !== 6'd32) begin
            bad++;
            $display("FAIL decode_r: rs=%0d rt=%0d rd=%0d sh=%0d fn=%0d required 2/3/4/0/32",
                     bus.rs, bus.rt, bus.rd, bus.sh, bus.fn);
        end
        bus.instr = 32'hFFFF_FFFF;
        #1;
        total++;
        if (bus.imm !== 32'h0000_FFFF || bus.op !== 6'h3F) begin
            bad++;
            $display("FAIL decode_zext: imm=%h op=%h required 0000ffff/3f", bus.imm, bus.op);
        end
    endtask

    task automatic test_add_sub();
        drive_cycle(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2);
        total++;
        if (bus.result !== 32'd1 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL add_wrap: result=%h valid=%b required 00000001/1", bus.result, bus.valid);
        end
        drive_cycle(1'b1, 3'd1, 32'd3, 32'd5);
        total++;
        if (bus.result !== 32'hFFFF_FFFE || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL sub_neg: result=%h valid=%b required fffffffe/1", bus.result, bus.valid);
        end
    endtask

    task automatic test_shifts();
        drive_cycle(1'b1, 3'd4, 32'd1, 32'd31);
        total++;
        if (bus.result !== 32'h8000_0000) begin
            bad++;
            $display("FAIL sll31: result=%h required 80000000", bus.result);
        end
        drive_cycle(1'b1, 3'd5, 32'h8000_0000, 32'd4);
        total++;
        if (bus.result !== 32'h0800_0000) begin
            bad++;
            $display("FAIL srl4: result=%h required 08000000", bus.result);
        end
        drive_cycle(1'b1, 3'd4, 32'd1, 32'd33);
        total++;
        if (bus.result !== 32'd2) begin
            bad++;
            $display("FAIL sll_amt_mask: result=%h required 00000002", bus.result);
        end
        drive_cycle(1'b1, 3'd6, 32'd1234, 32'd1);
        total++;
        if (bus.result !== 32'd0) begin
            bad++;
            $display("FAIL op110: result=%h required 0", bus.result);
        end
    endtask

    task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
        drive_cycle(1'b1, 3'd2, 32'd7, 32'd6);
        total++;
        if (bus.result !== 32'd42) begin bad++; $display("FAIL mul: result=%h required 2a", bus.result); end
        drive_cycle(1'b1, 3'd3, 32'd43, 32'd5);
        total++;
        if (bus.result !== 32'd8 || bus.div_by_zero !== 1'b0) begin
            bad++; $display("FAIL div: result=%h dbz=%b required 8/0", bus.result, bus.div_by_zero);
        end
        drive_cycle(1'b1, 3'd3, 32'd9, 32'd0);
        total++;
        if (bus.result !== 32'hFFFF_FFFF || bus.div_by_zero !== 1'b1) begin
            bad++; $display("FAIL div0: result=%h dbz=%b required ffffffff/1", bus.result, bus.div_by_zero);
        end
        drive_cycle(1'b0, 3'd0, 32'd1, 32'd1);
        total++;
        if (bus.div_by_zero !== 1'b1 || bus.valid !== 1'b0) begin
            bad++; $display("FAIL div0_hold: dbz=%b valid=%b required 1/0", bus.div_by_zero, bus.valid);
        end
        drive_cycle(1'b1, 3'd0, 32'd1, 32'd1);
        total++;
        if (bus.div_by_zero !== 1'b0 || bus.result !== 32'd2) begin
            bad++; $display("FAIL div0_clear: dbz=%b result=%h required 0/2", bus.div_by_zero, bus.result);
        end
`else
        drive_cycle(1'b1, 3'd2, 32'd7, 32'd6);
        total++;
        if (bus.result !== 32'd0) begin bad++; $display("FAIL mul_off: result=%h required 0", bus.result); end
        drive_cycle(1'b1, 3'd3, 32'd43, 32'd5);
        total++;
        if (bus.result !== 32'd0) begin bad++; $display("FAIL div_off: result=%h required 0", bus.result); end
        drive_cycle(1'b1, 3'd3, 32'd9, 32'd0);
        total++;
        if (bus.result !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            bad++; $display("FAIL div0_off: result=%h dbz=%b required 0/0", bus.result, bus.div_by_zero);
        end
`endif
    endtask

    task automatic test_hold();
        drive_cycle(1'b1, 3'd0, 32'd100, 32'd23);
        drive_cycle(1'b0, 3'd1, 32'd5, 32'd5);
        total++;
        if (bus.result !== 32'd123 || bus.valid !== 1'b0) begin
            bad++; $display("FAIL hold: result=%0d valid=%b required 123/0", bus.result, bus.valid);
        end
        drive_cycle(1'b0, 3'd4, 32'd7, 32'd7);
        total++;
        if (bus.result !== 32'd123 || bus.valid !== 1'b0) begin
            bad++; $display("FAIL hold2: result=%0d valid=%b required 123/0", bus.result, bus.valid);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 3'd0, 32'd40, 32'd2);
        // Assert reset mid-cycle, well away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.result !== 32'd0 || bus.valid !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            bad++; $display("FAIL async_rst: result=%h valid=%b dbz=%b required 0/0/0",
                            bus.result, bus.valid, bus.div_by_zero);
        end
        // Enabled request while reset is held must be discarded.
        bus.enable = 1'b1; bus.op_code = 3'd0; bus.operand1 = 32'd9; bus.operand2 = 32'd9;
        @(posedge clk); #1;
        total++;
        if (bus.result !== 32'd0 || bus.valid !== 1'b0) begin
            bad++; $display("FAIL rst_discard: result=%h valid=%b required 0/0", bus.result, bus.valid);
        end
        bus.enable = 1'b0;
        rst = 1'b0;
        exp_result = 0; exp_valid = 1'b0; exp_dbz = 1'b0;
        drive_cycle(1'b0, 3'd0, 32'd0, 32'd0);
        total++;
        if (bus.result !== 32'd0 || bus.valid !== 1'b0) begin
            bad++; $display("FAIL post_rst: result=%h valid=%b required 0/0", bus.result, bus.valid);
        end
    endtask

    task automatic test_random();
        logic        en;
        logic [2:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 60; i++) begin
            en  = ($urandom_range(0, 4) != 0);
            opc = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            drive_cycle(en, opc, a, b);
            total++;
            if (bus.result !== exp_result[31:0] || bus.valid !== exp_valid || bus.div_by_zero !== exp_dbz) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h valid=%b dbz=%b required %h/%b/%b",
                         i, opc, a, b, bus.result, bus.valid, bus.div_by_zero,
                         exp_result[31:0], exp_valid, exp_dbz);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.instr    = '0;
        bus.op_code  = '0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        bus.enable   = 1'b0;
        test_reset();
        test_decode();
        test_add_sub();
        test_shifts();
        test_muldiv();
        test_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpp_alu.md
GPP_ALU -- requirements
Module: gpp_alu

Interface
REQ-001 Parameter D_WIDTH, default 32, SHALL set the data width of operands and result.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 instr  input  32  SHALL be the instruction word to decode.
REQ-005 op_code  input  3  SHALL select the ALU operation.
REQ-006 operand1, operand2  input  D_WIDTH each  SHALL be the ALU operands.
REQ-007 enable  input  1  SHALL request one ALU operation in the current cycle.
REQ-008 op, rs, rt, rd, sh, fn  output  6/5/5/5/5/6  SHALL be the decoded instruction fields.
REQ-009 imm  output  D_WIDTH  SHALL be instr[15:0] zero-extended.
REQ-010 result  output  D_WIDTH  SHALL be the registered ALU result.
REQ-011 valid  output  1  SHALL be high for the cycle after an enabled operation.
REQ-012 div_by_zero  output  1  SHALL flag a registered divide with operand2 = 0.

Function
REQ-013 Decode SHALL be combinational: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0].
REQ-014 On a rising Clk with enable=1, result SHALL load f(op_code, operand1, operand2) and valid SHALL go 1 (latency 1 cycle).
REQ-015 On a rising Clk with enable=0, result and div_by_zero SHALL hold and valid SHALL go 0.
REQ-016 op_code 000 SHALL compute operand1+operand2, truncated to D_WIDTH (wrap-around, no carry out).
REQ-017 op_code 001 SHALL compute operand1-operand2, two's complement, truncated to D_WIDTH.
REQ-018 op_code 010 SHALL compute the low D_WIDTH bits of the unsigned product.
REQ-019 op_code 011 SHALL compute the unsigned quotient operand1/operand2, truncated toward zero.
REQ-020 Divide with operand2=0 SHALL give result all-ones and div_by_zero=1; any other enabled operation SHALL clear div_by_zero.
REQ-021 op_code 100 SHALL compute operand1 logically shifted left by operand2[4:0].
REQ-022 op_code 101 SHALL compute operand1 logically shifted right by operand2[4:0], zero-filling.
REQ-023 op_code 110 and 111 SHALL give result 0.
REQ-024 Shift amounts SHALL use only operand2[4:0]; upper operand2 bits SHALL be ignored.

Reset
REQ-025 While Rst=1, result SHALL be 0, valid 0 and div_by_zero 0, immediately and regardless of Clk.
REQ-026 An operation enabled in the cycle Rst asserts SHALL be discarded.
REQ-027 Decode outputs SHALL be unaffected by Rst.

Configuration
REQ-028 With macro ALU_MULDIV_EN defined, op_code 010/011 SHALL behave per REQ-018..020.
REQ-029 Without ALU_MULDIV_EN, op_code 010/011 SHALL give result 0, and div_by_zero SHALL stay 0.

Structure
REQ-030 A shared package SHALL hold D_WIDTH, the op_code constants (ADD, SUB, MUL, DIV, SLL, SRL) and the instruction field bit positions.
REQ-031 Field extraction SHALL sit in one combinational sub-module, instr_decoder.
REQ-032 The ALU datapath and output registers SHALL sit in gpp_alu.

Verification
REQ-033 instr=0x2001000A -> op=8, rs=0, rt=1, imm=10; instr=0x00432020 -> rs=2, rt=3, rd=4, sh=0, fn=32.
REQ-034 Add: operands 0xFFFFFFFF and 2 with enable=1 -> next cycle result=1, valid=1; sub: 3-5 -> 0xFFFFFFFE.
REQ-035 Shifts: sll of 1 by 31 -> 0x80000000; srl of 0x80000000 by 4 -> 0x08000000; shift of 1 by operand2=33 -> amount 1, result 2.
REQ-036 With ALU_MULDIV_EN: 7*6 -> 42; 43/5 -> 8; 9/0 -> 0xFFFFFFFF with div_by_zero=1. Without ALU_MULDIV_EN: the same stimuli -> 0.
REQ-037 Hold: enable=0 after an add -> result holds, valid=0; Rst pulse mid-stream -> result=0, valid=0 asynchronously.
